// File: rtl/ahb_default_slave_pkg.sv
// ---------------------------------------------------------------------------
// ahb_default_slave_pkg
// Shared AHB types for the default slave: transfer type, response type and
// the default-slave FSM state encoding. It also holds a small helper that
// tells whether a transfer type carries a real data phase.
// ---------------------------------------------------------------------------
package ahb_default_slave_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY   = 2'b01,
        NONSEQ = 2'b10,
        SEQ    = 2'b11
    } htrans_type;

    typedef enum logic [1:0] {
        OKAY  = 2'b00,
        ERROR = 2'b01,
        RETRY = 2'b10,
        SPLIT = 2'b11
    } hresp_type;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_ERR1 = 2'b10,
        ST_ERR2 = 2'b11
    } dslv_state_t;

    // The wait-state counter is wide enough for WAIT_CYCLES up to 15.
    localparam int WAIT_CNT_WIDTH = 4;

    // NONSEQ and SEQ are the only transfer types that need a data-phase answer.
    function automatic logic is_active_trans(input htrans_type trans);
        return (trans == NONSEQ) || (trans == SEQ);
    endfunction

endpackage

// File: rtl/ahb_default_slave_if.sv
// ---------------------------------------------------------------------------
// ahb_default_slave_if
// AHB signals between the bus fabric and the default slave.
//   hsel      - default-slave select (from the decoder's default_slv_sel)
//   haddr     - address-phase address
//   htrans    - transfer type
//   hwrite    - address-phase direction, 1 = write
//   hready    - bus-level HREADY, qualifies address phases
//   hreadyout - the slave's ready
//   hresp     - the slave's response
// The master modport drives the request side; the slave modport answers it.
// ---------------------------------------------------------------------------
interface ahb_default_slave_if
    import ahb_default_slave_pkg::*;
#(
    parameter int AHB_ADDR_WIDTH = 32
);

    logic                      hsel;
    logic [AHB_ADDR_WIDTH-1:0] haddr;
    htrans_type                htrans;
    logic                      hwrite;
    logic                      hready;
    logic                      hreadyout;
    hresp_type                 hresp;

    modport master (
        output hsel,
        output haddr,
        output htrans,
        output hwrite,
        output hready,
        input  hreadyout,
        input  hresp
    );

    modport slave (
        input  hsel,
        input  haddr,
        input  htrans,
        input  hwrite,
        input  hready,
        output hreadyout,
        output hresp
    );

endinterface

// File: rtl/ahb_default_slave_err_logger.sv
// ---------------------------------------------------------------------------
// ahb_err_logger
// Records error information for software in the default slave.
//   clk, rst_n     - clock and asynchronous active-low reset
//   err_strobe     - one-cycle pulse when a new ERROR response starts
//   err_addr_in    - address of that erroring transfer
//   err_write_in   - direction of that erroring transfer
//   err_clr        - one-cycle clear from software
//   err_irq        - sticky interrupt
//   err_addr/write - first error captured since the last clear
//   err_count      - saturating count of ERROR responses
// ---------------------------------------------------------------------------
module ahb_err_logger #(
    parameter int ADDR_WIDTH = 32,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  err_strobe,
    input  logic [ADDR_WIDTH-1:0] err_addr_in,
    input  logic                  err_write_in,
    input  logic                  err_clr,
    output logic                  err_irq,
    output logic [ADDR_WIDTH-1:0] err_addr,
    output logic                  err_write,
    output logic [CNT_WIDTH-1:0]  err_count
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic                  irq_q,   irq_d;
    logic                  valid_q, valid_d;
    logic [ADDR_WIDTH-1:0] addr_q,  addr_d;
    logic                  write_q, write_d;
    logic [CNT_WIDTH-1:0]  count_q, count_d;

    // A new error beats a simultaneous clear: the clear wipes the old history
    // and the new error becomes the first one recorded.
    always_comb begin
        irq_d   = irq_q;
        valid_d = valid_q;
        addr_d  = addr_q;
        write_d = write_q;
        count_d = count_q;

        if (err_strobe) begin
            irq_d = 1'b1;
            if (err_clr) begin
                count_d = CNT_ONE;
            end else if (count_q != CNT_MAX) begin
                count_d = count_q + CNT_ONE;
            end
            if (!valid_q || err_clr) begin
                addr_d  = err_addr_in;
                write_d = err_write_in;
                valid_d = 1'b1;
            end
        end else if (err_clr) begin
            // The captured address is left visible until the next capture.
            irq_d   = 1'b0;
            valid_d = 1'b0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_q   <= 1'b0;
            valid_q <= 1'b0;
            addr_q  <= '0;
            write_q <= 1'b0;
            count_q <= '0;
        end else begin
            irq_q   <= irq_d;
            valid_q <= valid_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            count_q <= count_d;
        end
    end

    assign err_irq   = irq_q;
    assign err_addr  = addr_q;
    assign err_write = write_q;
    assign err_count = count_q;

endmodule

// File: rtl/ahb_default_slave.sv
// ---------------------------------------------------------------------------
// ahb_default_slave
// AHB responder for addresses that hit no slave region. IDLE/BUSY get a
// zero-wait OKAY; NONSEQ/SEQ get optional OKAY wait states followed by the
// two-cycle ERROR response. Error details go to an error logger.
//   hclk, hreset_n - clock and asynchronous active-low reset
//   bus            - AHB slave-side signals (hsel, haddr, htrans, hwrite,
//                    hready in; hreadyout, hresp out)
//   err_clr        - one-cycle clear of irq, count and capture
//   err_irq        - sticky error interrupt
//   err_addr/write - first error captured since the last clear
//   err_count      - saturating count of ERROR responses
// ---------------------------------------------------------------------------
module ahb_default_slave
    import ahb_default_slave_pkg::*;
#(
    parameter int AHB_ADDR_WIDTH = 32,
    parameter int WAIT_CYCLES    = 0,
    parameter int CNT_WIDTH      = 8
) (
    input  logic                      hclk,
    input  logic                      hreset_n,
    ahb_default_slave_if.slave        bus,
    input  logic                      err_clr,
    output logic                      err_irq,
    output logic [AHB_ADDR_WIDTH-1:0] err_addr,
    output logic                      err_write,
    output logic [CNT_WIDTH-1:0]      err_count
);

    localparam bit HAS_WAIT = (WAIT_CYCLES > 0);
    localparam logic [WAIT_CNT_WIDTH-1:0] WAIT_LOAD =
        HAS_WAIT ? WAIT_CNT_WIDTH'(WAIT_CYCLES - 1) : '0;

    dslv_state_t               state_q, state_d;
    logic [WAIT_CNT_WIDTH-1:0] wait_cnt_q, wait_cnt_d;
    logic [AHB_ADDR_WIDTH-1:0] samp_addr_q, samp_addr_d;
    logic                      samp_write_q, samp_write_d;
    logic                      accept;
    logic                      err_strobe;
    logic                      hreadyout_o;
    hresp_type                 hresp_o;

    assign accept = bus.hsel && bus.hready && is_active_trans(bus.htrans);

    // ST_ERR2 behaves like ST_IDLE for the next address phase, so
    // back-to-back erroring transfers are answered without a gap. Once
    // started, a response always runs to completion whatever the master does.
    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        samp_addr_d  = samp_addr_q;
        samp_write_d = samp_write_q;
        hreadyout_o  = 1'b1;
        hresp_o      = OKAY;

        case (state_q)
            ST_IDLE, ST_ERR2: begin
                if (state_q == ST_ERR2) begin
                    hresp_o = ERROR;
                end
                if (accept) begin
                    samp_addr_d  = bus.haddr;
                    samp_write_d = bus.hwrite;
                    if (HAS_WAIT) begin
                        state_d    = ST_WAIT;
                        wait_cnt_d = WAIT_LOAD;
                    end else begin
                        state_d = ST_ERR1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                hreadyout_o = 1'b0;
                if (wait_cnt_q == '0) begin
                    state_d = ST_ERR1;
                end else begin
                    wait_cnt_d = wait_cnt_q - 1'b1;
                end
            end
            ST_ERR1: begin
                hreadyout_o = 1'b0;
                hresp_o     = ERROR;
                state_d     = ST_ERR2;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            state_q      <= ST_IDLE;
            wait_cnt_q   <= '0;
            samp_addr_q  <= '0;
            samp_write_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            samp_addr_q  <= samp_addr_d;
            samp_write_q <= samp_write_d;
        end
    end

    assign bus.hreadyout = hreadyout_o;
    assign bus.hresp     = hresp_o;

    // ERR1 can only be entered from a different state, so this is a
    // single-cycle pulse. The *_d sample values already hold the live bus
    // address when ERR1 is entered straight from an accept.
    assign err_strobe = (state_d == ST_ERR1);

    ahb_err_logger #(
        .ADDR_WIDTH (AHB_ADDR_WIDTH),
        .CNT_WIDTH  (CNT_WIDTH)
    ) u_err_logger (
        .clk          (hclk),
        .rst_n        (hreset_n),
        .err_strobe   (err_strobe),
        .err_addr_in  (samp_addr_d),
        .err_write_in (samp_write_d),
        .err_clr      (err_clr),
        .err_irq      (err_irq),
        .err_addr     (err_addr),
        .err_write    (err_write),
        .err_count    (err_count)
    );

endmodule

// File: tb/tb_ahb_default_slave.sv
// ---------------------------------------------------------------------------
// tb_ahb_default_slave
// Two default slaves share one stimulus stream: u_dut0 has no wait states
// and a 2-bit counter; u_dut2 has two wait states and an 8-bit counter.
// Inputs change on the falling edge and outputs are sampled there too.
// ---------------------------------------------------------------------------
module tb_ahb_default_slave;
    import ahb_default_slave_pkg::*;

    logic hclk = 1'b0;
    logic hreset_n;
    logic err_clr;

    always #5 hclk = ~hclk;

    ahb_default_slave_if #(.AHB_ADDR_WIDTH(32)) bus0 ();
    ahb_default_slave_if #(.AHB_ADDR_WIDTH(32)) bus2 ();

    logic        err_irq0, err_write0;
    logic [31:0] err_addr0;
    logic [1:0]  err_count0;
    logic        err_irq2, err_write2;
    logic [31:0] err_addr2;
    logic [7:0]  err_count2;

    int vectors_applied = 0;
    int miscompares     = 0;

    ahb_default_slave #(
        .AHB_ADDR_WIDTH (32),
        .WAIT_CYCLES    (0),
        .CNT_WIDTH      (2)
    ) u_dut0 (
        .hclk      (hclk),
        .hreset_n  (hreset_n),
        .bus       (bus0.slave),
        .err_clr   (err_clr),
        .err_irq   (err_irq0),
        .err_addr  (err_addr0),
        .err_write (err_write0),
        .err_count (err_count0)
    );

    ahb_default_slave #(
        .AHB_ADDR_WIDTH (32),
        .WAIT_CYCLES    (2),
        .CNT_WIDTH      (8)
    ) u_dut2 (
        .hclk      (hclk),
        .hreset_n  (hreset_n),
        .bus       (bus2.slave),
        .err_clr   (err_clr),
        .err_irq   (err_irq2),
        .err_addr  (err_addr2),
        .err_write (err_write2),
        .err_count (err_count2)
    );

    task automatic applyStimulus(input logic sel, input htrans_type trans,
                                 input logic [31:0] addr, input logic wr,
                                 input logic rdy, input logic clr);
        bus0.hsel   = sel;  bus2.hsel   = sel;
        bus0.htrans = trans; bus2.htrans = trans;
        bus0.haddr  = addr; bus2.haddr  = addr;
        bus0.hwrite = wr;   bus2.hwrite = wr;
        bus0.hready = rdy;  bus2.hready = rdy;
        err_clr     = clr;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors_applied++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic checkBus0(input string tag, input logic rdy, input hresp_type resp);
        checkOutput({tag, ".hreadyout"}, 32'(bus0.hreadyout), 32'(rdy));
        checkOutput({tag, ".hresp"}, 32'(bus0.hresp), 32'(resp));
    endtask

    task automatic checkBus2(input string tag, input logic rdy, input hresp_type resp);
        checkOutput({tag, ".hreadyout"}, 32'(bus2.hreadyout), 32'(rdy));
        checkOutput({tag, ".hresp"}, 32'(bus2.hresp), 32'(resp));
    endtask

    task automatic checkLog0(input string tag, input logic irq, input logic [31:0] addr,
                             input logic wr, input logic [1:0] cnt);
        checkOutput({tag, ".irq"}, 32'(err_irq0), 32'(irq));
        checkOutput({tag, ".addr"}, err_addr0, addr);
        checkOutput({tag, ".write"}, 32'(err_write0), 32'(wr));
        checkOutput({tag, ".count"}, 32'(err_count0), 32'(cnt));
    endtask

    task automatic doError(input logic [31:0] addr, input logic wr);
        applyStimulus(1'b1, NONSEQ, addr, wr, 1'b1, 1'b0);
        @(negedge hclk);
        applyStimulus(1'b1, IDLE, 32'h0, 1'b0, 1'b1, 1'b0);
        @(negedge hclk);
        @(negedge hclk);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed timeout, expected $finish");
        $fatal(1, "[TB] simulation timed out");
    end

    initial begin
        hreset_n = 1'b0;
        applyStimulus(1'b0, IDLE, 32'h0, 1'b0, 1'b1, 1'b0);
        repeat (2) @(negedge hclk);
        checkBus0("rst0", 1'b1, OKAY);
        checkLog0("rst0", 1'b0, 32'h0, 1'b0, 2'd0);
        checkBus2("rst2", 1'b1, OKAY);
        checkOutput("rst2.count", 32'(err_count2), 32'd0);
        hreset_n = 1'b1;

        // Phases that must not start a response.
        applyStimulus(1'b1, IDLE, 32'h3000, 1'b1, 1'b1, 1'b0);
        @(negedge hclk); checkBus0("idle", 1'b1, OKAY);
        applyStimulus(1'b1, BUSY, 32'h3000, 1'b1, 1'b1, 1'b0);
        @(negedge hclk); checkBus0("busy", 1'b1, OKAY);
        applyStimulus(1'b1, NONSEQ, 32'h3000, 1'b1, 1'b0, 1'b0);
        @(negedge hclk); checkBus0("nordy", 1'b1, OKAY);
        applyStimulus(1'b0, NONSEQ, 32'h3000, 1'b1, 1'b1, 1'b0);
        @(negedge hclk); checkBus0("nosel", 1'b1, OKAY);
        checkLog0("nosel", 1'b0, 32'h0, 1'b0, 2'd0);

        // Single error with zero wait states.
        applyStimulus(1'b1, NONSEQ, 32'h0000_3000, 1'b1, 1'b1, 1'b0);
        @(negedge hclk); checkBus0("err1", 1'b0, ERROR);
        checkLog0("err1", 1'b1, 32'h0000_3000, 1'b1, 2'd1);
        applyStimulus(1'b1, IDLE, 32'h0, 1'b0, 1'b1, 1'b0);
        @(negedge hclk); checkBus0("err2", 1'b1, ERROR);
        @(negedge hclk); checkBus0("post", 1'b1, OKAY);

        // Clear alone keeps the captured address.
        applyStimulus(1'b1, IDLE, 32'h0, 1'b0, 1'b1, 1'b1);
        @(negedge hclk);
        applyStimulus(1'b1, IDLE, 32'h0, 1'b0, 1'b1, 1'b0);
        checkLog0("clr", 1'b0, 32'h0000_3000, 1'b1, 2'd0);

        // Back-to-back: SEQ presented in ERR1 is ignored, accepted in ERR2.
        applyStimulus(1'b1, NONSEQ, 32'h0000_3000, 1'b0, 1'b1, 1'b0);
        @(negedge hclk); checkBus0("b2b.a1", 1'b0, ERROR);
        applyStimulus(1'b1, SEQ, 32'h0000_3004, 1'b1, 1'b1, 1'b0);
        @(negedge hclk); checkBus0("b2b.a2", 1'b1, ERROR);
        @(negedge hclk); checkBus0("b2b.b1", 1'b0, ERROR);
        applyStimulus(1'b1, IDLE, 32'h0, 1'b0, 1'b1, 1'b0);
        @(negedge hclk); checkBus0("b2b.b2", 1'b1, ERROR);
        checkLog0("b2b", 1'b1, 32'h0000_3000, 1'b0, 2'd2);
        @(negedge hclk); checkBus0("b2b.end", 1'b1, OKAY);

        // Counter saturation with a 2-bit counter.
        applyStimulus(1'b1, IDLE, 32'h0, 1'b0, 1'b1, 1'b1);
        @(negedge hclk);
        for (int i = 0; i < 5; i++) begin
            doError(32'h0000_0100 + 32'(i), 1'b0);
        end
        checkLog0("sat", 1'b1, 32'h0000_0100, 1'b0, 2'd3);
        applyStimulus(1'b1, IDLE, 32'h0, 1'b0, 1'b1, 1'b1);
        @(negedge hclk);
        applyStimulus(1'b1, IDLE, 32'h0, 1'b0, 1'b1, 1'b0);
        checkLog0("clr2", 1'b0, 32'h0000_0100, 1'b0, 2'd0);
        doError(32'h0000_6000, 1'b1);
        checkLog0("cap", 1'b1, 32'h0000_6000, 1'b1, 2'd1);

        // Clear together with a new error: the new error wins.
        applyStimulus(1'b1, NONSEQ, 32'h0000_7000, 1'b0, 1'b1, 1'b1);
        @(negedge hclk); checkBus0("clrhit", 1'b0, ERROR);
        checkLog0("clrhit", 1'b1, 32'h0000_7000, 1'b0, 2'd1);
        applyStimulus(1'b1, IDLE, 32'h0, 1'b0, 1'b1, 1'b0);
        repeat (2) @(negedge hclk);

        // Asynchronous reset in the middle of ERR1.
        applyStimulus(1'b1, NONSEQ, 32'h0000_8000, 1'b1, 1'b1, 1'b0);
        @(negedge hclk); checkBus0("pre_rst", 1'b0, ERROR);
        checkOutput("pre_rst.count", 32'(err_count0), 32'd2);
        applyStimulus(1'b1, IDLE, 32'h0, 1'b0, 1'b1, 1'b0);
        #2 hreset_n = 1'b0;
        #1 checkBus0("arst", 1'b1, OKAY);
        checkOutput("arst.count", 32'(err_count0), 32'd0);
        checkOutput("arst.irq", 32'(err_irq0), 32'd0);
        @(negedge hclk);
        hreset_n = 1'b1;

        // Two wait states, with bus changes during the wait ignored.
        applyStimulus(1'b1, NONSEQ, 32'h0000_5004, 1'b1, 1'b1, 1'b0);
        @(negedge hclk); checkBus2("w1", 1'b0, OKAY);
        applyStimulus(1'b1, IDLE, 32'h0000_9990, 1'b0, 1'b1, 1'b0);
        @(negedge hclk); checkBus2("w2", 1'b0, OKAY);
        @(negedge hclk); checkBus2("w.e1", 1'b0, ERROR);
        checkOutput("w.count", 32'(err_count2), 32'd1);
        checkOutput("w.addr", err_addr2, 32'h0000_5004);
        checkOutput("w.write", 32'(err_write2), 32'd1);
        @(negedge hclk); checkBus2("w.e2", 1'b1, ERROR);
        @(negedge hclk); checkBus2("w.end", 1'b1, OKAY);

        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end

endmodule

// File: doc/ahb_default_slave.md
Name: ahb_default_slave

Overview:
- AHB responder for accesses that fall outside every slave region of the address map.
- Selected by the master-side decoder's default_slv_sel output.
- Answers IDLE/BUSY transfers with a zero-wait OKAY.
- Answers NONSEQ/SEQ transfers with the mandatory two-cycle ERROR response, after optional wait states.
- Captures the first failing address and direction, counts errors, and raises a sticky interrupt for software.

Parameters:
- AHB_ADDR_WIDTH, 32, haddr width.
- WAIT_CYCLES, 0, number of OKAY wait-state cycles (hreadyout=0) inserted before the ERROR response; legal range 0..15.
- CNT_WIDTH, 8, width of the saturating error counter.

Ports:
- hclk  in  1  system clock, rising edge.
- hreset_n  in  1  asynchronous active-low reset.
- hsel  in  1  default-slave select, driven from the decoder's default_slv_sel.
- haddr  in  AHB_ADDR_WIDTH  address-phase address.
- htrans  in  htrans_type  transfer type (IDLE/BUSY/NONSEQ/SEQ).
- hwrite  in  1  address-phase direction, 1 = write.
- hready  in  1  bus-level HREADY (mux output); qualifies address phases.
- hreadyout  out  1  this slave's ready.
- hresp  out  hresp_type  this slave's response.
- err_clr  in  1  single-cycle pulse; clears err_irq, err_count and the capture-valid flag.
- err_irq  out  1  sticky error interrupt.
- err_addr  out  AHB_ADDR_WIDTH  haddr of the first error since the last clear.
- err_write  out  1  hwrite of the first error since the last clear.
- err_count  out  CNT_WIDTH  saturating count of ERROR responses.

Behaviour:
- One clock (hclk). Reset is asynchronous, active-low (hreset_n).
- Reset values: hreadyout=1, hresp=OKAY, state=ST_IDLE, wait counter=0, err_irq=0, err_addr=0, err_write=0, err_count=0, capture-valid=0.
- Valid address phase (accept): hsel & hready & (htrans==NONSEQ | htrans==SEQ).
- Non-accepting phase: hsel & hready & htrans in {IDLE, BUSY}, or !hsel. State stays/returns to ST_IDLE, giving OKAY with hreadyout=1 in the next cycle.
- FSM states:
  - ST_IDLE: hreadyout=1, hresp=OKAY. On accept: go to ST_WAIT if WAIT_CYCLES>0 (wait counter loaded with WAIT_CYCLES-1), else go to ST_ERR1.
  - ST_WAIT: hreadyout=0, hresp=OKAY. Counter decrements each cycle. At 0, go to ST_ERR1.
  - ST_ERR1: hreadyout=0, hresp=ERROR. Always go to ST_ERR2 next cycle.
  - ST_ERR2: hreadyout=1, hresp=ERROR. Acts as ST_IDLE for the next address phase: accept gives back-to-back errors (ST_WAIT or ST_ERR1), otherwise go to ST_IDLE.
- Address/direction are sampled only on accept. htrans/haddr changes during ST_WAIT/ST_ERR1 are ignored; master cancellation to IDLE after ERR1 does not shorten the response.
- hsel deassertion while in ST_WAIT/ST_ERR1 does not abort; the response always completes.
- Latency with WAIT_CYCLES=0: accept at cycle N; hresp=ERROR in N+1 (hreadyout=0) and N+2 (hreadyout=1).
- Capture: on entry to ST_ERR1, err_count increments and saturates at 2^CNT_WIDTH-1. err_irq is set. If capture-valid=0, load err_addr/err_write from the sampled values and set capture-valid.
- err_clr in the same cycle as ERR1 entry: the new error wins. err_count=1, err_irq=1, capture reloaded with the new error.
- err_clr alone: err_count=0, err_irq=0, capture-valid=0. err_addr keeps its value until the next capture.
- Asynchronous reset mid-response returns to ST_IDLE immediately with the reset values above.

Decomposition:
- AHB_package: htrans_type (existing); add hresp_type enum {OKAY, ERROR, RETRY, SPLIT} = 2'b00..2'b11 if not already present; add dslv_state_t {ST_IDLE, ST_WAIT, ST_ERR1, ST_ERR2}.
- One sub-module, ahb_err_logger: capture registers, saturating counter, irq. Its inputs are the capture strobe, sampled addr/write and err_clr.
- The FSM stays in the top module.

Test Plan:
- WAIT_CYCLES=0: hsel=1, hready=1, NONSEQ, haddr=32'h0000_3000, hwrite=1 at cycle 5 -> cycle 6 {hreadyout=0, ERROR}; cycle 7 {1, ERROR}; err_addr=32'h0000_3000, err_write=1, err_count=1, err_irq=1.
- IDLE then BUSY with hsel=1 -> hreadyout=1, hresp=OKAY every cycle; err_count stays 0.
- WAIT_CYCLES=2: NONSEQ at 32'h0000_5004 -> 2 cycles {0, OKAY}, then {0, ERROR}, then {1, ERROR}.
- Back-to-back: NONSEQ 32'h0000_3000, then SEQ 32'h0000_3004 accepted during ST_ERR2 -> two complete ERROR pairs; err_count=2; err_addr stays 32'h0000_3000.
- CNT_WIDTH=2: 5 errors -> err_count=3 (saturated). err_clr pulse -> count 0, irq 0. err_clr coincident with a new ERR1 entry -> count=1, irq=1, err_addr=new address.
- hreset_n low during ST_ERR1 -> hreadyout=1, hresp=OKAY, err_count=0 immediately, without waiting for a clock edge.
